// File: rtl/cdc_hs_sample.sv
// Two-clock word transfer using a toggle req/ack handshake; clk1 source side, clk2 destination side.
// The hold register is the only multi-bit crossing and stays quasi-static while a request is in flight.
module cdc_hs_sample #(
  parameter int              DW          = 32,
  parameter int              SYNC_STAGES = 2,
  parameter int              CNT_W       = 16,
  parameter logic [DW-1:0]   RST_VAL     = '0
) (
  input  logic             clk2,
  input  logic             rstn,
  input  logic             clk1,
  input  logic [DW-1:0]    src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} src_state_t;

  src_state_t             state_q, state_d;
  logic                   req_tgl, req_tgl_d, hold_en;
  logic [DW-1:0]          hold;
  logic [SYNC_STAGES-1:0] ack_sync_q, req_sync_q;
  logic                   ack_sync, ack_tgl, req_s, req_seen, new_req;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign new_req  = req_s ^ req_seen;

  // ---- clk1 domain: source FSM, request toggle, ack synchroniser
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      req_tgl    <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      req_tgl    <= req_tgl_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl};
    end
  end

  always_ff @(posedge clk1) begin
    if (hold_en) hold <= src_data;
  end

  // Once the returning ack matches req_tgl the source is ready on that same edge,
  // so a waiting word can be accepted without an extra IDLE cycle.
  always_comb begin
    state_d   = state_q;
    req_tgl_d = req_tgl;
    hold_en   = 1'b0;
    src_ready = 1'b0;
    case (state_q)
      IDLE: src_ready = 1'b1;
      WAIT_ACK: begin
        if (ack_sync == req_tgl) begin
          src_ready = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (src_ready && src_valid) begin
      hold_en   = 1'b1;
      req_tgl_d = ~req_tgl;
      state_d   = WAIT_ACK;
    end
  end

  // ---- clk2 domain: request synchroniser, output register, ack toggle, counter
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      req_sync_q <= '0;
      req_seen   <= 1'b0;
      dout       <= RST_VAL;
      dout_valid <= 1'b0;
      ack_tgl    <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tgl};
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        ack_tgl    <= ~ack_tgl;
        xfer_cnt   <= xfer_cnt + 1'b1;
      end else if (new_req) begin
        dout       <= hold;
        dout_valid <= 1'b1;
        req_seen   <= req_s;
      end
    end
  end

endmodule

// File: tb/tb_cdc_hs_sample.sv
// Bench for cdc_hs_sample: scenario tasks with a queue-based reference of accepted vs delivered words.
`timescale 1ns/1ps
module tb_cdc_hs_sample;
  localparam int          DW = 32;
  localparam int          SS = 2;
  localparam int          CW = 4;
  localparam logic [31:0] RV = 32'hA5A5_0F0F;

  logic          clk1 = 1'b0;
  logic          clk2 = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic [CW-1:0] xfer_cnt;

  int   half1 = 50;
  int   half2 = 5;
  int   total = 0;
  int   bad = 0;
  int   exp_xfer = 0;
  bit   rdy_rand = 1'b0;
  logic rdy_fixed = 1'b1;
  logic [31:0] got_q[$];

  cdc_hs_sample #(.DW(DW), .SYNC_STAGES(SS), .CNT_W(CW), .RST_VAL(RV)) dut (
    .clk2(clk2), .rstn(rstn), .clk1(clk1),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .xfer_cnt(xfer_cnt)
  );

  always #(half1) clk1 = ~clk1;
  initial begin
    #1;
    forever #(half2) clk2 = ~clk2;
  end

  initial forever begin
    @(negedge clk2);
    dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Every completed destination handshake, in order.
  always @(posedge clk2) begin
    if (rstn && dout_valid && dout_ready) got_q.push_back(dout);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] d, output bit ok);
    int g = 0;
    ok = 1'b0;
    @(negedge clk1);
    while (!src_ready && g < 200) begin
      @(negedge clk1);
      g++;
    end
    if (src_ready) begin
      src_data  = d;
      src_valid = 1'b1;
      @(posedge clk1);
      #1;
      src_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic wait_got(input int n, output bit ok);
    int g = 0;
    while (got_q.size() < n && g < 2000) begin
      @(posedge clk2);
      #1;
      g++;
    end
    @(posedge clk2);
    #1;
    ok = (got_q.size() >= n);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #5;
    @(negedge clk1);
    #2;
    rstn = 1'b1;
    exp_xfer = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #20;
    total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL reset_src_ready: got %b want 1", src_ready); end
    total++; if (dout !== RV) begin bad++; $display("FAIL reset_dout: got %h want %h", dout, RV); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); end
    @(negedge clk1);
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int n = 0;
    int m = 0;
    send_word(32'hDEADBEEF, ok);
    while (n < 20) begin
      @(posedge clk2);
      #1;
      n++;
      if (dout_valid) break;
    end
    total++; if (!ok || dout_valid !== 1'b1 || n < SS + 1 || n > SS + 2) begin
      bad++; $display("FAIL single_latency: got %0d clk2 edges (valid=%b) want %0d..%0d", n, dout_valid, SS + 1, SS + 2);
    end
    total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", dout); end
    @(posedge clk2);
    #1;
    exp_xfer++;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_width: valid still %b after one cycle", dout_valid); end
    total++; if (xfer_cnt !== CW'(exp_xfer)) begin bad++; $display("FAIL single_cnt: got %0d want %0d", xfer_cnt, CW'(exp_xfer)); end
    while (m < 10) begin
      @(posedge clk1);
      #1;
      m++;
      if (src_ready) break;
    end
    total++; if (src_ready !== 1'b1 || m < SS || m > SS + 1) begin
      bad++; $display("FAIL single_ready_return: got %0d clk1 edges want %0d..%0d", m, SS, SS + 1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int g = 0;
    int unstable = 0;
    int base = got_q.size();
    logic [31:0] w = $urandom;
    rdy_fixed = 1'b0;
    @(negedge clk2);
    @(negedge clk2);
    send_word(w, ok);
    while (!dout_valid && g < 50) begin
      @(posedge clk2);
      #1;
      g++;
    end
    total++; if (!ok || dout_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_rise: got %b want 1", dout_valid); end
    repeat (50) begin
      @(posedge clk2);
      #1;
      if (dout !== w || dout_valid !== 1'b1 || src_ready !== 1'b0) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
    rdy_fixed = 1'b1;
    @(posedge clk2);
    #1;
    rdy_fixed = 1'b0;
    exp_xfer++;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL bp_consume: valid %b want 0", dout_valid); end
    total++; if (got_q.size() != base + 1 || got_q[base] !== w) begin
      bad++; $display("FAIL bp_word: got %0d words want 1 of value %h", got_q.size() - base, w);
    end
    total++; if (xfer_cnt !== CW'(exp_xfer)) begin bad++; $display("FAIL bp_cnt: got %0d want %0d", xfer_cnt, CW'(exp_xfer)); end
    rdy_fixed = 1'b1;
  endtask

  task automatic test_wait_change();
    bit ok;
    int g = 0;
    int base = got_q.size();
    logic [31:0] w = $urandom;
    send_word(w, ok);
    while (g < 200) begin
      @(negedge clk1);
      if (src_ready) break;
      src_data  = $urandom;
      src_valid = 1'b1;
      g++;
    end
    src_valid = 1'b0;
    repeat (30) @(posedge clk2);
    #1;
    exp_xfer++;
    total++; if (!ok || got_q.size() != base + 1) begin bad++; $display("FAIL wc_count: got %0d words want 1", got_q.size() - base); end
    total++; if (got_q.size() > base && got_q[base] !== w) begin bad++; $display("FAIL wc_data: got %h want %h", got_q[base], w); end
    total++; if (xfer_cnt !== CW'(exp_xfer)) begin bad++; $display("FAIL wc_cnt: got %0d want %0d", xfer_cnt, CW'(exp_xfer)); end
  endtask

  task automatic test_continuous();
    bit ok;
    int g = 0;
    int k = 1;
    int base = got_q.size();
    int base2;
    logic [31:0] sent_q[$];
    half1 = int'($urandom_range(5, 50));
    half2 = int'($urandom_range(5, 50));
    rdy_fixed = 1'b1;
    src_data = 32'(k);
    while (k <= 16 && g < 2000) begin
      @(negedge clk1);
      src_valid = 1'b1;
      g++;
      if (src_ready) begin
        @(posedge clk1);
        #1;
        k++;
        if (k > 16) src_valid = 1'b0;
        else src_data = 32'(k);
      end
    end
    src_valid = 1'b0;
    wait_got(base + 16, ok);
    repeat (20) @(posedge clk2);
    #1;
    exp_xfer += 16;
    total++; if (!ok || got_q.size() != base + 16) begin bad++; $display("FAIL cont_count: got %0d words want 16", got_q.size() - base); end
    for (int i = 0; i < 16; i++) begin
      if (base + i < got_q.size()) begin
        total++; if (got_q[base + i] !== 32'(i + 1)) begin bad++; $display("FAIL cont_word%0d: got %h want %h", i, got_q[base + i], 32'(i + 1)); end
      end
    end
    total++; if (xfer_cnt !== CW'(exp_xfer)) begin bad++; $display("FAIL cont_cnt: got %0d want %0d", xfer_cnt, CW'(exp_xfer)); end
    base2 = got_q.size();
    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] w = $urandom;
      send_word(w, ok);
      if (ok) sent_q.push_back(w);
    end
    wait_got(base2 + sent_q.size(), ok);
    rdy_rand = 1'b0;
    repeat (20) @(posedge clk2);
    #1;
    exp_xfer += 20;
    total++; if (sent_q.size() != 20 || got_q.size() != base2 + 20) begin
      bad++; $display("FAIL rand_count: sent %0d delivered %0d want 20", sent_q.size(), got_q.size() - base2);
    end
    for (int i = 0; i < sent_q.size(); i++) begin
      if (base2 + i < got_q.size()) begin
        total++; if (got_q[base2 + i] !== sent_q[i]) begin bad++; $display("FAIL rand_word%0d: got %h want %h", i, got_q[base2 + i], sent_q[i]); end
      end
    end
    total++; if (xfer_cnt !== CW'(exp_xfer)) begin bad++; $display("FAIL rand_cnt: got %0d want %0d", xfer_cnt, CW'(exp_xfer)); end
    half1 = 50;
    half2 = 5;
    repeat (3) @(posedge clk1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int spur = 0;
    int base;
    logic [31:0] w2 = $urandom;
    send_word(32'hCAFE_F00D, ok);
    @(posedge clk2);
    #1;
    rstn = 1'b0;
    #3;
    @(negedge clk1);
    #2;
    rstn = 1'b1;
    exp_xfer = 0;
    base = got_q.size();
    repeat (30) begin
      @(posedge clk2);
      #1;
      if (dout_valid !== 1'b0) spur++;
    end
    total++; if (spur != 0) begin bad++; $display("FAIL rmid_spurious_valid: got %0d cycles want 0", spur); end
    total++; if (dout !== RV) begin bad++; $display("FAIL rmid_dout: got %h want %h", dout, RV); end
    total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL rmid_src_ready: got %b want 1", src_ready); end
    total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", xfer_cnt); end
    send_word(w2, ok);
    wait_got(base + 1, ok);
    exp_xfer++;
    total++; if (!ok || got_q.size() != base + 1 || got_q[base] !== w2) begin
      bad++; $display("FAIL rmid_next_xfer: got %0d words want 1 of value %h", got_q.size() - base, w2);
    end
    total++; if (xfer_cnt !== CW'(exp_xfer)) begin bad++; $display("FAIL rmid_next_cnt: got %0d want %0d", xfer_cnt, CW'(exp_xfer)); end
  endtask

  task automatic test_wrap();
    bit ok;
    int base;
    int wrong = 0;
    pulse_reset();
    base = got_q.size();
    for (int i = 1; i <= 17; i++) begin
      send_word(32'(i * 7 + 3), ok);
      wait_got(base + i, ok);
      exp_xfer++;
      if (!ok || got_q[base + i - 1] !== 32'(i * 7 + 3)) wrong++;
      if (i == 16) begin
        total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL wrap_at16: got %0d want 0", xfer_cnt); end
      end
    end
    total++; if (wrong != 0) begin bad++; $display("FAIL wrap_words: got %0d bad words want 0", wrong); end
    total++; if (xfer_cnt !== CW'(exp_xfer)) begin bad++; $display("FAIL wrap_after17: got %0d want %0d", xfer_cnt, CW'(exp_xfer)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wait_change();
    test_continuous();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
